pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and status controller for a five-stage pipeline.
// Detects load-use, mispredict, return and exception conditions, drives the
// per-stage stall/bubble controls, and keeps saturating performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal operation, M and W stage status both AOK
// S_DRAIN | exception sitting in M, waiting for it to reach W
// S_HALTED| exception reached W; pipeline frozen until reset
module pipe_ctrl #(
  parameter int BYTE_W = 4,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] D_icode_i,
  input  logic [BYTE_W-1:0] E_icode_i,
  input  logic [BYTE_W-1:0] M_icode_i,
  input  logic [BYTE_W-1:0] E_dstM_i,
  input  logic [BYTE_W-1:0] d_srcA_i,
  input  logic [BYTE_W-1:0] d_srcB_i,
  input  logic              e_Cnd_i,
  input  logic [BYTE_W-1:0] m_stat_i,
  input  logic [BYTE_W-1:0] W_stat_i,
  output logic              F_stall_o,
  output logic              D_stall_o,
  output logic              W_stall_o,
  output logic              D_bubble_o,
  output logic              E_bubble_o,
  output logic              M_bubble_o,
  output logic              halted_o,
  output logic [BYTE_W-1:0] cpu_stat_o,
  output logic [WORD_W-1:0] cycle_cnt_o,
  output logic [WORD_W-1:0] lu_cnt_o,
  output logic [WORD_W-1:0] mp_cnt_o,
  output logic [WORD_W-1:0] ret_cnt_o
);

  localparam logic [BYTE_W-1:0] I_JXX    = BYTE_W'(7);
  localparam logic [BYTE_W-1:0] I_RET    = BYTE_W'(9);
  localparam logic [BYTE_W-1:0] I_MRMOVL = BYTE_W'(5);
  localparam logic [BYTE_W-1:0] I_POPL   = BYTE_W'(11);
  localparam logic [BYTE_W-1:0] R_NONE   = BYTE_W'(15);
  localparam logic [BYTE_W-1:0] S_AOK    = BYTE_W'(1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BYTE_W-1:0] r_cpu_stat;
  logic [WORD_W-1:0] r_cycle_cnt;
  logic [WORD_W-1:0] r_lu_cnt;
  logic [WORD_W-1:0] r_mp_cnt;
  logic [WORD_W-1:0] r_ret_cnt;

  logic w_load_use;
  logic w_mispred;
  logic w_ret_pend;
  logic w_exc_m;
  logic w_exc_w;
  logic w_active;

  assign w_load_use = ((E_icode_i == I_MRMOVL) || (E_icode_i == I_POPL)) &&
                      (E_dstM_i != R_NONE) &&
                      ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign w_mispred  = (E_icode_i == I_JXX) && !e_Cnd_i;
  assign w_ret_pend = (D_icode_i == I_RET) || (E_icode_i == I_RET) ||
                      (M_icode_i == I_RET);
  assign w_exc_m    = (m_stat_i != S_AOK);
  assign w_exc_w    = (W_stat_i != S_AOK);
  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v,
                                                input logic en);
    return (en && (v != '1)) ? v + WORD_W'(1) : v;
  endfunction

  // State register and status latch captured on the edge into HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_cpu_stat <= S_AOK;
    end else begin
      r_state <= w_state_nxt;
      if (w_active && w_exc_w) r_cpu_stat <= W_stat_i;
    end
  end

  // Next-state and control outputs; reset overrides everything with a flush.
  always_comb begin
    w_state_nxt = r_state;
    F_stall_o   = w_load_use | w_ret_pend;
    D_stall_o   = w_load_use;
    D_bubble_o  = w_mispred | (w_ret_pend & ~w_load_use);
    E_bubble_o  = w_mispred | w_load_use;
    M_bubble_o  = w_exc_m | w_exc_w;
    W_stall_o   = w_exc_w;
    case (r_state)
      S_RUN: begin
        if (w_exc_w)      w_state_nxt = S_HALTED;
        else if (w_exc_m) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_exc_w) w_state_nxt = S_HALTED;
      end
      S_HALTED: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (rst) begin
      F_stall_o  = 1'b0;
      D_stall_o  = 1'b0;
      W_stall_o  = 1'b0;
      D_bubble_o = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
    end
  end

  // Performance counters advance only while the pipeline is live.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_lu_cnt    <= '0;
      r_mp_cnt    <= '0;
      r_ret_cnt   <= '0;
    end else if (w_active) begin
      r_cycle_cnt <= sat_inc(r_cycle_cnt, 1'b1);
      r_lu_cnt    <= sat_inc(r_lu_cnt, w_load_use);
      r_mp_cnt    <= sat_inc(r_mp_cnt, w_mispred);
      r_ret_cnt   <= sat_inc(r_ret_cnt, w_ret_pend);
    end
  end

  assign halted_o    = (r_state == S_HALTED);
  assign cpu_stat_o  = r_cpu_stat;
  assign cycle_cnt_o = r_cycle_cnt;
  assign lu_cnt_o    = r_lu_cnt;
  assign mp_cnt_o    = r_mp_cnt;
  assign ret_cnt_o   = r_ret_cnt;

endmodule
